instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_wait_timer.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared CPU types and constants for the fetch stage
package instruction_fetch_unit_pkg;

    typedef logic [15:0] word_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } fetch_state_e;

    localparam word_t DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/instruction_fetch_unit_wait_timer.sv
// rtl/instruction_fetch_unit_wait_timer.sv - 8-bit loadable down-counter bounding memory wait time
module fetch_wait_timer
    import instruction_fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  byte_t load_value,
    input  logic  en,
    output logic  zero
);

    byte_t count_q, count_d;

    // Saturates at zero so a late enable can never wrap into a fresh budget.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - owns the PC and assembles 16-bit instructions from byte-wide memory
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam byte_t TIMEOUT_LOAD = byte_t'(TIMEOUT_CYCLES);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        ir_q, ir_d;
    word_t        start_pc_q, start_pc_d;
    logic         mem_read_q, mem_read_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic         timer_load, timer_en, timer_zero;

    fetch_wait_timer u_wait_timer (
        .clk        (Clock),
        .rst_n      (Reset),
        .load       (timer_load),
        .load_value (TIMEOUT_LOAD),
        .en         (timer_en),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        start_pc_d = start_pc_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PCLoad) begin
                    pc_d = PCIn;
                end else if (Start) begin
                    start_pc_d = pc_q;
                    timer_load = 1'b1;
                    state_d    = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                // Data arriving on the limit cycle still wins over the timeout.
                if (MemReady) begin
                    ir_d[7:0]  = MemData;
                    pc_d       = pc_q + 16'd1;
                    timer_load = 1'b1;
                    state_d    = ST_FETCH_HI;
                end else if (timer_zero) begin
                    pc_d    = start_pc_q;
                    state_d = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_FETCH_HI: begin
                if (MemReady) begin
                    ir_d[15:8] = MemData;
                    pc_d       = pc_q + 16'd1;
                    state_d    = ST_DONE;
                end else if (timer_zero) begin
                    pc_d    = start_pc_q;
                    state_d = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        mem_read_d = (state_d == ST_FETCH_LO) || (state_d == ST_FETCH_HI);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            start_pc_q <= RESET_PC;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            start_pc_q <= start_pc_d;
            mem_read_q <= mem_read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign MemAddr = pc_q;
    assign PC      = pc_q;
    assign IR      = ir_q;
    assign MemRead = mem_read_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Error   = error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit with a byte memory responder
module tb_instruction_fetch_unit;

    localparam int TB_TIMEOUT = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        PCLoad = 1'b0;
    logic [15:0] PCIn = 16'h0000;
    logic [7:0]  MemData;
    logic        MemReady = 1'b0;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic [15:0] IR;
    logic [15:0] PC;
    logic        Busy;
    logic        Done;
    logic        Error;

    typedef struct {
        bit          is_err;
        logic [15:0] ir;
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] mem [0:65535];
    int         stall_lo = 0;
    int         stall_hi = 0;
    bit         hang_hi  = 1'b0;
    int         byte_idx = 0;
    int         wait_n   = 0;

    instruction_fetch_unit #(
        .RESET_PC       (16'h0000),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .PCLoad   (PCLoad),
        .PCIn     (PCIn),
        .MemData  (MemData),
        .MemReady (MemReady),
        .MemAddr  (MemAddr),
        .MemRead  (MemRead),
        .IR       (IR),
        .PC       (PC),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    assign MemData = mem[MemAddr];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: stalls a programmable number of cycles per byte.
    always @(negedge Clock) begin
        if (MemReady) begin
            byte_idx++;
            wait_n = 0;
        end
        if (!MemRead) begin
            byte_idx = 0;
            wait_n   = 0;
            MemReady = 1'b0;
        end else if ((byte_idx == 0) ? (wait_n >= stall_lo) : (!hang_hi && wait_n >= stall_hi)) begin
            MemReady = 1'b1;
        end else begin
            MemReady = 1'b0;
            wait_n++;
        end
    end

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Reset && (Done || Error)) begin
            check("done_error_exclusive", {31'd0, Done & Error}, 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: Done=%b Error=%b at cycle %0d, expected none", Done, Error, cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind_error", {31'd0, Error}, {31'd0, e.is_err});
                check("event_ir", IR, e.ir);
                check("event_pc", PC, e.pc);
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("idle_within_bound", {31'd0, Busy}, 32'd0);
    endtask

    task automatic fetch(bit is_err, logic [15:0] ir, logic [15:0] pc, int extra);
        @(negedge Clock);
        Start = 1'b1;
        sb.push_back('{is_err, ir, pc, cyc + 3 + extra});
        @(negedge Clock);
        Start = 1'b0;
        wait_idle();
    endtask

    task automatic load_pc(logic [15:0] v);
        @(negedge Clock);
        PCLoad = 1'b1;
        PCIn   = v;
        @(negedge Clock);
        PCLoad = 1'b0;
        check("pc_load", PC, v);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge Clock);
        check("reset_pc", PC, 16'h0000);
        check("reset_ir", IR, 16'h0000);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_error", {31'd0, Error}, 32'd0);
        check("reset_memread", {31'd0, MemRead}, 32'd0);
        Reset = 1'b1;

        // Zero-wait fetch from address 0
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        @(negedge Clock);
        Start = 1'b1;
        sb.push_back('{1'b0, 16'h1234, 16'h0002, cyc + 3});
        @(negedge Clock);
        Start = 1'b0;
        check("addr_lo", MemAddr, 16'h0000);
        check("memread_lo", {31'd0, MemRead}, 32'd1);
        check("busy_fetch", {31'd0, Busy}, 32'd1);
        @(negedge Clock);
        check("addr_hi", MemAddr, 16'h0001);
        wait_idle();
        check("t1_ir", IR, 16'h1234);
        check("t1_pc", PC, 16'h0002);

        // Fetch straddling the top of the address space
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        load_pc(16'hFFFF);
        fetch(1'b0, 16'hABCD, 16'h0001, 0);
        check("wrap_pc", PC, 16'h0001);

        // PCLoad beats Start in the same cycle
        mem[16'h0100] = 8'h78;
        mem[16'h0101] = 8'h56;
        @(negedge Clock);
        PCLoad = 1'b1;
        Start  = 1'b1;
        PCIn   = 16'h0100;
        @(negedge Clock);
        PCLoad = 1'b0;
        Start  = 1'b0;
        check("load_start_pc", PC, 16'h0100);
        check("load_start_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        check("load_start_busy2", {31'd0, Busy}, 32'd0);
        fetch(1'b0, 16'h5678, 16'h0102, 0);

        // Wait states: 3 on low byte, 2 on high byte
        mem[16'h0102] = 8'hEF;
        mem[16'h0103] = 8'hBE;
        stall_lo = 3;
        stall_hi = 2;
        fetch(1'b0, 16'hBEEF, 16'h0104, 5);

        // Data on the exact limit cycle is accepted
        mem[16'h0104] = 8'h11;
        mem[16'h0105] = 8'h22;
        stall_lo = TB_TIMEOUT;
        stall_hi = 0;
        fetch(1'b0, 16'h2211, 16'h0106, TB_TIMEOUT);

        // One stall beyond the limit on the low byte times out
        stall_lo = TB_TIMEOUT + 1;
        fetch(1'b1, 16'h2211, 16'h0106, TB_TIMEOUT - 1);

        // High byte never arrives
        mem[16'h0106] = 8'h99;
        stall_lo = 0;
        hang_hi  = 1'b1;
        fetch(1'b1, 16'h2299, 16'h0106, TB_TIMEOUT);
        check("hang_ir_hi_kept", {24'd0, IR[15:8]}, 32'h22);
        check("hang_pc_restored", PC, 16'h0106);

        // Asynchronous reset in the middle of FETCH_HI
        mem[16'h0200] = 8'h5A;
        load_pc(16'h0200);
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        check("async_pc", PC, 16'h0000);
        check("async_ir", IR, 16'h0000);
        check("async_busy", {31'd0, Busy}, 32'd0);
        check("async_memread", {31'd0, MemRead}, 32'd0);
        repeat (3) @(negedge Clock);
        hang_hi = 1'b0;
        Reset   = 1'b1;
        repeat (10) @(negedge Clock);
        check("post_reset_busy", {31'd0, Busy}, 32'd0);
        check("post_reset_ir", IR, 16'h0000);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
